// File: rtl/pc_stack_unit.sv
// ---------------------------------------------------------------------------
// pc_stack_unit
//
// Program-counter unit for the fetch stage. Each clock edge the PC either
// increments, takes a signed relative branch, takes an absolute jump, calls a
// subroutine (pushing the return address on an internal LIFO), returns (pops
// the LIFO into the PC), or holds (Halt / Fault). A Call on a full stack or a
// Ret on an empty stack sets a sticky Fault that freezes the unit until Reset.
//
// Parameters
//   PCW      PC / instruction-address width in bits
//   RSD      return-stack depth in entries (>= 1)
//   RESET_PC PC value loaded on reset
//
// Ports
//   CLK        in   clock, all state changes on the rising edge
//   Reset      in   synchronous, active-high reset
//   Halt       in   hold PC and stack while high
//   Branch     in   PC <- PC + Offset
//   Offset     in   signed branch offset (PCW bits)
//   Jump       in   PC <- Target
//   Call       in   push PC+1, PC <- Target
//   Ret        in   pop top of stack into PC
//   Target     in   absolute destination for Jump / Call
//   PC         out  current instruction address (registered)
//   Depth      out  number of valid return-stack entries
//   StackFull  out  Depth == RSD
//   StackEmpty out  Depth == 0
//   Fault      out  sticky overflow / underflow flag (registered)
//
// Action priority within one edge:
//   Reset > Fault > Halt > Ret > Call > Jump > Branch > increment
// ---------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int              PCW      = 16,
    parameter int              RSD      = 4,
    parameter logic [PCW-1:0]  RESET_PC = '0
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       Halt,
    input  logic                       Branch,
    input  logic signed [PCW-1:0]      Offset,
    input  logic                       Jump,
    input  logic                       Call,
    input  logic                       Ret,
    input  logic [PCW-1:0]             Target,
    output logic [PCW-1:0]             PC,
    output logic [$clog2(RSD+1)-1:0]   Depth,
    output logic                       StackFull,
    output logic                       StackEmpty,
    output logic                       Fault
);

    localparam int DW = $clog2(RSD + 1);
    // Index width into the stack array; a one-entry stack still needs a bit.
    localparam int IW = (RSD > 1) ? $clog2(RSD) : 1;

    typedef enum logic [2:0] {
        A_HOLD,
        A_RET,
        A_UFLOW,
        A_CALL,
        A_OFLOW,
        A_JUMP,
        A_BRANCH,
        A_INC
    } act_t;

    // Modulo-2^PCW address arithmetic; carries out of the top bit are dropped.
    function automatic logic [PCW-1:0] f_pc_add(input logic [PCW-1:0] a,
                                                 input logic [PCW-1:0] b);
        return a + b;
    endfunction

    logic [PCW-1:0] r_pc;
    logic [DW-1:0]  r_depth;
    logic           r_fault;
    logic [PCW-1:0] r_stack [RSD];

    act_t           w_act;
    logic [PCW-1:0] w_pc_inc;
    logic [PCW-1:0] w_pc_br;
    logic [DW-1:0]  w_depth_m1;
    logic [IW-1:0]  w_push_idx;
    logic [IW-1:0]  w_pop_idx;
    logic           w_full;
    logic           w_empty;
    logic [PCW-1:0] w_pc_nxt;
    logic [DW-1:0]  w_depth_nxt;
    logic           w_fault_nxt;
    logic           w_push;

    assign w_pc_inc   = f_pc_add(r_pc, PCW'(1));
    assign w_pc_br    = f_pc_add(r_pc, $unsigned(Offset));
    assign w_depth_m1 = r_depth - DW'(1);
    // Push slot is the current depth, pop slot is one below it; neither is
    // used when it would fall outside the array (full / empty cases fault).
    assign w_push_idx = r_depth[IW-1:0];
    assign w_pop_idx  = w_depth_m1[IW-1:0];
    assign w_full     = (r_depth == DW'(RSD));
    assign w_empty    = (r_depth == '0);

    // Action select: a single winner per edge by fixed priority.
    always_comb begin
        w_act = A_INC;
        if (r_fault || Halt) begin
            w_act = A_HOLD;
        end else if (Ret) begin
            w_act = w_empty ? A_UFLOW : A_RET;
        end else if (Call) begin
            w_act = w_full ? A_OFLOW : A_CALL;
        end else if (Jump) begin
            w_act = A_JUMP;
        end else if (Branch) begin
            w_act = A_BRANCH;
        end
    end

    // Next-state values for PC, depth, fault and the push strobe.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_depth_nxt = r_depth;
        w_fault_nxt = r_fault;
        w_push      = 1'b0;
        unique case (w_act)
            A_HOLD:   ;
            A_RET: begin
                w_pc_nxt    = r_stack[w_pop_idx];
                w_depth_nxt = w_depth_m1;
            end
            A_UFLOW:  w_fault_nxt = 1'b1;
            A_CALL: begin
                w_pc_nxt    = Target;
                w_depth_nxt = r_depth + DW'(1);
                w_push      = 1'b1;
            end
            A_OFLOW:  w_fault_nxt = 1'b1;
            A_JUMP:   w_pc_nxt    = Target;
            A_BRANCH: w_pc_nxt    = w_pc_br;
            A_INC:    w_pc_nxt    = w_pc_inc;
            default:  ;
        endcase
    end

    // Control state: PC, depth and fault all move on the same edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc    <= RESET_PC;
            r_depth <= '0;
            r_fault <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_depth <= w_depth_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Stack storage carries no reset; Depth alone defines which entries are
    // valid. Reset still suppresses the write so a Call colliding with Reset
    // leaves nothing behind.
    always_ff @(posedge CLK) begin
        if (!Reset && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign PC         = r_pc;
    assign Depth      = r_depth;
    assign StackFull  = w_full;
    assign StackEmpty = w_empty;
    assign Fault      = r_fault;

endmodule

// File: tb/tb_pc_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_stack_unit
//
// Self-checking bench for pc_stack_unit (PCW=16, RSD=4, RESET_PC=0).
// A table of per-cycle vectors covers the directed scenarios, a few
// hand-written sequences cover reset collisions and return-address wrap,
// and a randomized run compares against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pc_stack_unit;

    localparam int              PCW      = 16;
    localparam int              RSD      = 4;
    localparam logic [PCW-1:0]  RESET_PC = '0;
    localparam int              DW       = $clog2(RSD + 1);

    logic                 CLK = 1'b0;
    logic                 Reset, Halt, Branch, Jump, Call, Ret;
    logic signed [PCW-1:0] Offset;
    logic [PCW-1:0]       Target;
    logic [PCW-1:0]       PC;
    logic [DW-1:0]        Depth;
    logic                 StackFull, StackEmpty, Fault;

    int checks = 0;
    int errors = 0;

    pc_stack_unit #(.PCW(PCW), .RSD(RSD), .RESET_PC(RESET_PC)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Halt       (Halt),
        .Branch     (Branch),
        .Offset     (Offset),
        .Jump       (Jump),
        .Call       (Call),
        .Ret        (Ret),
        .Target     (Target),
        .PC         (PC),
        .Depth      (Depth),
        .StackFull  (StackFull),
        .StackEmpty (StackEmpty),
        .Fault      (Fault)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit             rst, halt, br, jmp, call, ret;
        logic [PCW-1:0] off, tgt;
        logic [PCW-1:0] epc;
        int             edep;
        bit             eflt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit halt, bit br, bit jmp, bit call, bit ret,
                                logic [PCW-1:0] off, logic [PCW-1:0] tgt,
                                logic [PCW-1:0] epc, int edep, bit eflt);
        vec_t v;
        v.rst = rst; v.halt = halt; v.br = br; v.jmp = jmp; v.call = call; v.ret = ret;
        v.off = off; v.tgt = tgt; v.epc = epc; v.edep = edep; v.eflt = eflt;
        vecs.push_back(v);
    endfunction

    // Drive controls, let one rising edge pass, then sample 1 time unit later.
    task automatic step(bit rst, bit halt, bit br, bit jmp, bit call, bit ret,
                        logic [PCW-1:0] off, logic [PCW-1:0] tgt);
        Reset = rst; Halt = halt; Branch = br; Jump = jmp; Call = call; Ret = ret;
        Offset = off; Target = tgt;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(string name, logic [PCW-1:0] epc, int edep, bit eflt);
        logic exp_full, exp_empty;
        exp_full  = (edep == RSD);
        exp_empty = (edep == 0);
        checks++;
        if (PC !== epc || Depth !== DW'(edep) || Fault !== eflt ||
            StackFull !== exp_full || StackEmpty !== exp_empty) begin
            errors++;
            $display("FAIL %s: got PC=%h Depth=%0d Full=%b Empty=%b Fault=%b, want PC=%h Depth=%0d Full=%b Empty=%b Fault=%b",
                     name, PC, Depth, StackFull, StackEmpty, Fault,
                     epc, edep, exp_full, exp_empty, eflt);
        end
    endtask

    // Reference model state for the randomized run.
    logic [PCW-1:0] m_pc;
    logic [PCW-1:0] m_stk[$];
    bit             m_flt;

    task automatic model_step(bit rst, bit halt, bit br, bit jmp, bit call, bit ret,
                              logic [PCW-1:0] off, logic [PCW-1:0] tgt);
        if (rst) begin
            m_pc = RESET_PC;
            m_stk.delete();
            m_flt = 0;
        end else if (m_flt || halt) begin
            // frozen
        end else if (ret) begin
            if (m_stk.size() == 0) m_flt = 1;
            else m_pc = m_stk.pop_back();
        end else if (call) begin
            if (m_stk.size() == RSD) m_flt = 1;
            else begin
                m_stk.push_back(PCW'(int'(m_pc) + 1));
                m_pc = tgt;
            end
        end else if (jmp) begin
            m_pc = tgt;
        end else if (br) begin
            m_pc = PCW'(int'(m_pc) + int'($signed(off)));
        end else begin
            m_pc = PCW'(int'(m_pc) + 1);
        end
    endtask

    initial begin
        //   rst h br j  c  r  off      tgt      epc      dep flt
        // Reset then idle.
        add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0003, 0, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 0, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0005, 0, 0);
        // Nested calls from PC=5.
        add(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0040, 16'h0040, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0041, 1, 0);
        add(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0080, 16'h0080, 2, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0042, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0006, 0, 0);
        // Branches from PC=10, self-loop, wrap.
        add(0, 0, 0, 1, 0, 0, 16'h0000, 16'h000A, 16'h000A, 0, 0);
        add(0, 0, 1, 0, 0, 0, 16'h0006, 16'h0000, 16'h0010, 0, 0);
        add(0, 0, 1, 0, 0, 0, 16'hFFFD, 16'h0000, 16'h000D, 0, 0);
        add(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h000D, 0, 0);
        add(0, 0, 0, 1, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        // Underflow at PC=7; Halt and Jump ignored; Reset clears.
        add(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0007, 16'h0007, 0, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0007, 0, 1);
        add(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0007, 0, 1);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0007, 0, 1);
        add(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0003, 16'h0007, 0, 1);
        add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        // Priority: reach PC=20 with top=3.
        add(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0002, 16'h0002, 0, 0);
        add(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0014, 16'h0014, 1, 0);
        add(0, 1, 0, 1, 0, 1, 16'h0000, 16'h0055, 16'h0014, 1, 0);
        add(0, 0, 1, 1, 1, 1, 16'h0001, 16'h0055, 16'h0003, 0, 0);
        add(0, 0, 1, 1, 0, 0, 16'h0001, 16'h0030, 16'h0030, 0, 0);
        // Overflow: five Calls, then frozen, then Reset.
        add(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0100, 16'h0100, 1, 0);
        add(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0200, 16'h0200, 2, 0);
        add(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0300, 16'h0300, 3, 0);
        add(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0400, 16'h0400, 4, 0);
        add(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0500, 16'h0400, 4, 1);
        add(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0009, 16'h0400, 4, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0400, 4, 1);
        add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        // Pushed return address wraps: Call at 0xFFFF returns to 0.
        add(0, 0, 0, 1, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 0);
        add(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0050, 16'h0050, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].halt, vecs[i].br, vecs[i].jmp,
                 vecs[i].call, vecs[i].ret, vecs[i].off, vecs[i].tgt);
            check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].edep, vecs[i].eflt);
        end

        // Reset colliding with back-to-back Calls leaves an empty stack:
        // a following Ret must underflow rather than pop a stale entry.
        step(1, 0, 0, 0, 0, 0, 16'h0, 16'h0000);
        step(0, 0, 0, 0, 1, 0, 16'h0, 16'h0010);
        check("rc_call1", 16'h0010, 1, 0);
        step(0, 0, 0, 0, 1, 0, 16'h0, 16'h0020);
        check("rc_call2", 16'h0020, 2, 0);
        step(1, 0, 0, 0, 1, 0, 16'h0, 16'h0030);
        check("rc_reset", RESET_PC, 0, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0000);
        check("rc_ret_uflow", RESET_PC, 0, 1);

        // Reset wins even while Fault is set and Halt is high.
        step(1, 1, 0, 0, 1, 1, 16'h0, 16'h0077);
        check("reset_over_all", RESET_PC, 0, 0);

        // Full-stack LIFO order: four pushes pop back in reverse.
        step(0, 0, 0, 0, 1, 0, 16'h0, 16'h1000);
        step(0, 0, 0, 0, 1, 0, 16'h0, 16'h2000);
        step(0, 0, 0, 0, 1, 0, 16'h0, 16'h3000);
        step(0, 0, 0, 0, 1, 0, 16'h0, 16'h4000);
        check("lifo_full", 16'h4000, 4, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        check("lifo_pop1", 16'h3001, 3, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        check("lifo_pop2", 16'h2001, 2, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        check("lifo_pop3", 16'h1001, 1, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        check("lifo_pop4", 16'h0001, 0, 0);

        // Randomized run against the reference model.
        step(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        model_step(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        check("rnd_reset", m_pc, m_stk.size(), m_flt);
        for (int n = 0; n < 600; n++) begin
            bit             r_rst, r_halt, r_br, r_jmp, r_call, r_ret;
            logic [PCW-1:0] r_off, r_tgt;
            r_rst  = m_flt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            r_halt = ($urandom_range(0, 9) == 0);
            r_ret  = ($urandom_range(0, 4) == 0);
            r_call = ($urandom_range(0, 3) == 0);
            r_jmp  = ($urandom_range(0, 7) == 0);
            r_br   = ($urandom_range(0, 4) == 0);
            r_off  = PCW'($urandom());
            r_tgt  = PCW'($urandom());
            step(r_rst, r_halt, r_br, r_jmp, r_call, r_ret, r_off, r_tgt);
            model_step(r_rst, r_halt, r_br, r_jmp, r_call, r_ret, r_off, r_tgt);
            check($sformatf("rnd%0d", n), m_pc, m_stk.size(), m_flt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit for the fetch stage. It advances the PC and supports signed relative branches, absolute jumps, and subroutine call/return through an internal return-address stack. Halt freezes the PC. Stack misuse raises a sticky fault that also freezes the PC. The unit drives the instruction-memory address and replaces the fixed-width forward/backward-jump PC.

## Interface
Parameters:
- PCW, 16, PC / address width in bits
- RSD, 4, return-stack depth in entries (≥1)
- RESET_PC, 0, PC value loaded on reset

Ports:
- CLK  in  1  clock; all state updates on posedge
- Reset  in  1  reset, synchronous, active-high
- Halt  in  1  level; freeze PC and stack while high
- Branch  in  1  relative branch: PC ← PC + Offset
- Offset  in  PCW  signed two's-complement branch offset
- Jump  in  1  absolute jump: PC ← Target
- Call  in  1  push PC+1, then PC ← Target
- Ret  in  1  pop top of stack into PC
- Target  in  PCW  absolute destination for Jump/Call
- PC  out  PCW  current instruction address (registered)
- Depth  out  $clog2(RSD+1)  number of valid stack entries
- StackFull  out  1  Depth == RSD (combinational from Depth)
- StackEmpty  out  1  Depth == 0 (combinational from Depth)
- Fault  out  1  sticky stack overflow/underflow flag (registered)

## Operation
- Each posedge applies exactly one action, chosen by fixed priority: Reset > Fault > Halt > Ret > Call > Jump > Branch > increment. Lower-priority requests in the same cycle are ignored, not queued.
- Reset: PC ← RESET_PC, Depth ← 0, Fault ← 0. Stack contents are don't-care.
- Fault high: PC, Depth and stack hold. Only Reset clears Fault.
- Halt: PC, Depth and stack hold. Fault is unchanged.
- Ret with Depth > 0: PC ← stack[Depth-1], Depth ← Depth-1.
- Ret with Depth == 0 (underflow): Fault ← 1. PC and Depth hold.
- Call with Depth < RSD: stack[Depth] ← PC+1, Depth ← Depth+1, PC ← Target.
- Call with Depth == RSD (overflow): Fault ← 1. PC, Depth and stack hold.
- Jump: PC ← Target. Stack untouched.
- Branch: PC ← PC + sign-extended Offset, modulo 2^PCW. A negative Offset moves backward. Offset == 0 holds the PC, which is a legal self-loop.
- Default: PC ← PC + 1, modulo 2^PCW. Increment wraps from all-ones to 0.
- Pushed return address PC+1 also wraps modulo 2^PCW.
- The stack is LIFO. Only the top entry is observable, and only via Ret.

## Timing
- Single-cycle: a control sampled at posedge N is visible on PC after posedge N. No pipeline bubble.
- Depth, StackFull, StackEmpty and Fault update on the same edge as PC.
- A faulting Call/Ret sets Fault on that edge. From the next cycle all controls, including Halt, are ignored until Reset.
- Reset asserted mid-sequence, e.g. during back-to-back Calls, wins at that edge. The stack is emptied and no partial push or pop is retained.
- Reset values: PC = RESET_PC, Depth = 0, StackEmpty = 1, StackFull = 0, Fault = 0.
- Controls need not be one-hot. Priority resolves conflicts in the same cycle.

## Test plan
- Reset then idle 5 cycles (RESET_PC=0) -> PC = 0,1,2,3,4,5. Depth = 0, StackEmpty = 1, Fault = 0.
- PC=10: Branch with Offset=+6, then Offset=-3 (0xFFFD) -> PC = 16, then 13. With PC = 0xFFFF and no control -> PC = 0x0000.
- Nested calls: at PC=5 Call Target=0x40, at PC=0x41 Call Target=0x80, then Ret, Ret -> PC = 0x40, 0x41, 0x80, 0x42, 6. Depth steps 1, 1, 2, 1, 0.
- Overflow (RSD=4): five consecutive Calls -> first four push, fifth sets Fault. PC stays at the fourth Target and Depth = 4. Subsequent Jump and Ret are ignored until Reset, after which PC = RESET_PC and Fault = 0.
- Underflow: Ret with Depth=0 at PC=7 -> Fault = 1, PC stays 7. Asserting Halt, then Reset -> clears.
- Priority: at PC=20 with Depth=1 (top=3), assert Halt+Ret+Jump -> PC holds 20. Drop Halt, keeping Ret+Call+Jump+Branch -> PC = 3, Depth = 0. Next cycle Jump+Branch with Target=0x30, Offset=+1 -> PC = 0x30.
